opl3_write_queue: RTL and testbench

Write-pacing queue between the ISA/CPU port interface and the OPL3 synthesizer. Captures every rising edge of the CPU write strobe into a small FIFO and replays the writes to the OPL3 with a guaranteed minimum spacing: short after index writes, long after data writes. CPU bursts (e.g. `rep outsb`) therefore never overrun the synthesizer's register-update path. The block lives in the `clk` domain, directly upstream of `opl3`; its outputs drive `opl3.addr`, `din` and `we`.

---
 rtl/opl3_pkg.sv | 19 +
 rtl/opl3_wq_fifo.sv | 66 ++++++
 rtl/opl3_write_queue.sv | 159 +++++++++++++++
 tb/tb_opl3_write_queue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/opl3_pkg.sv
// opl3_pkg: types and defaults shared by the OPL3 write-pacing queue and its FIFO.
package opl3_pkg;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] data;
  } opl3_wr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } opl3_wq_state_e;

  localparam int unsigned OPL3_WQ_DEPTH_DEF    = 16;
  localparam int unsigned OPL3_WQ_ADDR_GAP_DEF = 8;
  localparam int unsigned OPL3_WQ_DATA_GAP_DEF = 64;

endpackage

// File: rtl/opl3_wq_fifo.sv
// opl3_wq_fifo: circular FIFO of OPL3 writes; push ignored when full, pop ignored when empty.
module opl3_wq_fifo
  import opl3_pkg::*;
#(
  parameter int unsigned DEPTH = OPL3_WQ_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  opl3_wr_t                 din,
  output opl3_wr_t                 dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL_CNT = (AW+1)'(DEPTH);

  opl3_wr_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign full      = (r_count == L_FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rptr];
  assign w_do_push = push & ~full & ~clear;
  assign w_do_pop  = pop & ~empty & ~clear;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/opl3_write_queue.sv
// opl3_write_queue: captures CPU write strobes and replays them to the OPL3 with a minimum gap.
// Build option OPL3_WQ_DROP_STATS_EN: enables the saturating dropped-write counter on drop_cnt.
module opl3_write_queue
  import opl3_pkg::*;
#(
  parameter int unsigned DEPTH    = OPL3_WQ_DEPTH_DEF,
  parameter int unsigned ADDR_GAP = OPL3_WQ_ADDR_GAP_DEF,
  parameter int unsigned DATA_GAP = OPL3_WQ_DATA_GAP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  input  logic       we,
  output logic [1:0] out_addr,
  output logic [7:0] out_din,
  output logic       out_we,
  output logic       busy,
  output logic       full,
  output logic       overflow,
  output logic [7:0] drop_cnt
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned GMAX = (DATA_GAP > ADDR_GAP) ? DATA_GAP : ADDR_GAP;
  localparam int unsigned GW   = (GMAX > 2) ? $clog2(GMAX) : 1;
  localparam logic [GW-1:0] L_ADDR_LD = GW'(ADDR_GAP - 2);
  localparam logic [GW-1:0] L_DATA_LD = GW'(DATA_GAP - 2);

  logic            r_we_d;
  logic            w_push_req;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  opl3_wr_t        w_wr;
  opl3_wr_t        w_head;
  logic [AW:0]     w_count;
  logic            w_full;
  logic            w_empty;
  logic [GW-1:0]   w_gap_ld;

  opl3_wq_state_e  r_state;
  logic [GW-1:0]   r_gap_cnt;
  logic            r_out_we;
  logic [1:0]      r_out_addr;
  logic [7:0]      r_out_din;
  logic            r_overflow;

  assign w_push_req = we & ~r_we_d;
  assign w_push     = w_push_req & ~flush;
  // Full is judged on the count before this cycle's pop, so a full queue drops even while popping.
  assign w_drop     = w_push_req & ~flush & w_full;
  assign w_pop      = (r_state == IDLE) & ~w_empty & ~flush;
  assign w_wr       = '{addr: addr, data: din};
  assign w_gap_ld   = r_out_addr[0] ? L_DATA_LD : L_ADDR_LD;

  opl3_wq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_wr),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we_d <= 1'b0;
    end else begin
      r_we_d <= we;
    end
  end

  // GAP leaves one count early so IDLE's pop cycle completes the gap: rises are exactly N apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gap_cnt  <= '0;
      r_out_we   <= 1'b0;
      r_out_addr <= '0;
      r_out_din  <= '0;
    end else begin
      r_out_we <= 1'b0;
      if (flush) begin
        r_state   <= IDLE;
        r_gap_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_pop) begin
              r_out_addr <= w_head.addr;
              r_out_din  <= w_head.data;
              r_out_we   <= 1'b1;
              r_state    <= ISSUE;
            end
          end
          ISSUE: begin
            r_gap_cnt <= w_gap_ld;
            r_state   <= (w_gap_ld == '0) ? IDLE : GAP;
          end
          GAP: begin
            if (r_gap_cnt <= GW'(1)) begin
              r_gap_cnt <= '0;
              r_state   <= IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt - GW'(1);
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

`ifdef OPL3_WQ_DROP_STATS_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (flush) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

  assign out_we   = r_out_we;
  assign out_addr = r_out_addr;
  assign out_din  = r_out_din;
  assign busy     = (w_count != '0) || (r_state != IDLE);
  assign full     = w_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_opl3_write_queue.sv
// tb_opl3_write_queue: scoreboard bench for the OPL3 write-pacing queue (default parameters).
`timescale 1ns/1ps
module tb_opl3_write_queue;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned ADDR_GAP = 8;
  localparam int unsigned DATA_GAP = 64;
`ifdef OPL3_WQ_DROP_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       we    = 1'b0;
  logic [1:0] addr  = '0;
  logic [7:0] din   = '0;
  logic [1:0] out_addr;
  logic [7:0] out_din;
  logic       out_we;
  logic       busy;
  logic       full;
  logic       overflow;
  logic [7:0] drop_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc   = 0;
  logic [9:0]  sb[$];
  int          rises[$];
  logic        prev_we    = 1'b0;
  bit          gap_ref_ok = 1'b0;
  int          last_rise  = 0;
  logic        last_a0    = 1'b0;

  opl3_write_queue #(
    .DEPTH    (DEPTH),
    .ADDR_GAP (ADDR_GAP),
    .DATA_GAP (DATA_GAP)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .addr     (addr),
    .din      (din),
    .we       (we),
    .out_addr (out_addr),
    .out_din  (out_din),
    .out_we   (out_we),
    .busy     (busy),
    .full     (full),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: every OPL3 write pulse is matched against the scoreboard head.
  initial forever begin
    logic [9:0] exp_wr;
    @(negedge clk);
    if (rst_n && out_we) begin
      check("we_pulse", 32'(prev_we), 32'd0);
      if (gap_ref_ok)
        check("gap_min", 32'((cyc - last_rise) >= int'(last_a0 ? DATA_GAP : ADDR_GAP)), 32'd1);
      if (sb.size() == 0) begin
        check("spurious_we", 32'(out_we), 32'd0);
      end else begin
        exp_wr = sb.pop_front();
        check("wr_data", {22'd0, out_addr, out_din}, {22'd0, exp_wr});
      end
      rises.push_back(cyc);
      last_rise  = cyc;
      last_a0    = out_addr[0];
      gap_ref_ok = 1'b1;
    end
    prev_we = out_we;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input bit accept);
    addr = a;
    din  = d;
    we   = 1'b1;
    if (accept) sb.push_back({a, d});
    tick();
    we = 1'b0;
    tick();
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k = 0;
    while (rises.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("rise_timeout", 32'(rises.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int c;
    int r;
    int base;
    int nr;

    repeat (3) tick();
    check("rst_out_we",   32'(out_we),   32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_out_din",  32'(out_din),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_full",     32'(full),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Single index write into an idle queue.
    c = cyc;
    wr(2'd0, 8'hBD, 1'b1);
    wait_rises(1, 20);
    r = rises[0];
    check("single_latency", 32'(r - c), 32'd2);
    while (cyc < r + int'(ADDR_GAP) - 2) tick();
    check("busy_in_gap", 32'(busy), 32'd1);
    tick();
    check("busy_fall", 32'(busy), 32'd0);

    // Alternating index/data burst on back-to-back strobes.
    nr = rises.size();
    c  = cyc;
    wr(2'd0, 8'h20, 1'b1);
    wr(2'd1, 8'h41, 1'b1);
    wr(2'd0, 8'hA0, 1'b1);
    wr(2'd1, 8'h1F, 1'b1);
    wait_rises(nr + 4, 300);
    check("burst_latency", 32'(rises[nr] - c), 32'd2);
    check("burst_sp0", 32'(rises[nr+1] - rises[nr]),   ADDR_GAP);
    check("burst_sp1", 32'(rises[nr+2] - rises[nr+1]), DATA_GAP);
    check("burst_sp2", 32'(rises[nr+3] - rises[nr+2]), ADDR_GAP);
    wait_idle(100);

    // Fill while the FSM sits in a data gap: 16 accepted, the 17th dropped.
    base = rises.size();
    wr(2'd1, 8'h55, 1'b1);
    for (int i = 0; i < 17; i++) wr(2'd0, 8'(8'h80 + i), i < 16);
    check("fill_full",     32'(full),     32'd1);
    check("fill_overflow", 32'(overflow), 32'd1);
    check("fill_drop_cnt", 32'(drop_cnt), 32'(STATS));
    r = rises[base];

    // Push lands on the same edge as the IDLE pop of a full queue: still dropped.
    while (cyc < r + int'(DATA_GAP) - 1) tick();
    addr = 2'd0;
    din  = 8'hEE;
    we   = 1'b1;
    tick();
    check("pop_out_we",      32'(out_we),   32'd1);
    check("drop_full_after", 32'(full),     32'd0);
    check("drop_overflow",   32'(overflow), 32'd1);
    check("drop_cnt_two",    32'(drop_cnt), 32'(2 * STATS));
    we = 1'b0;
    wait_rises(base + 17, 200);
    nr = rises.size();
    repeat (40) tick();
    check("drain_no_extra", 32'(rises.size() - nr), 32'd0);
    wait_idle(20);

    // Flush during a data gap with 5 entries queued.
    base = rises.size();
    wr(2'd1, 8'h66, 1'b1);
    for (int i = 0; i < 5; i++) wr(2'd0, 8'(8'hC0 + i), 1'b0);
    check("pre_flush_busy", 32'(busy), 32'd1);
    gap_ref_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy",     32'(busy),     32'd0);
    check("flush_full",     32'(full),     32'd0);
    check("flush_overflow", 32'(overflow), 32'd0);
    check("flush_drop_cnt", 32'(drop_cnt), 32'd0);
    repeat (100) tick();
    check("flush_no_we", 32'(rises.size() - (base + 1)), 32'd0);

    // Reset pulse mid-gap with one entry still queued.
    nr = rises.size();
    wr(2'd1, 8'h3C, 1'b1);
    wait_rises(nr + 1, 20);
    wr(2'd0, 8'h11, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_out_we",   32'(out_we),   32'd0);
    check("arst_out_addr", 32'(out_addr), 32'd0);
    check("arst_out_din",  32'(out_din),  32'd0);
    check("arst_busy",     32'(busy),     32'd0);
    check("arst_full",     32'(full),     32'd0);
    tick();
    rst_n = 1'b1;
    gap_ref_ok = 1'b0;
    nr = rises.size();
    repeat (100) tick();
    check("arst_no_we", 32'(rises.size() - nr), 32'd0);

    // Queue still works normally after reset.
    c = cyc;
    wr(2'd1, 8'h99, 1'b1);
    wait_rises(nr + 1, 20);
    check("post_rst_latency", 32'(rises[nr] - c), 32'd2);
    wait_idle(100);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
